branch_pc_ctrl: RTL and testbench
=================================

Name: branch_pc_ctrl

Overview:
Program-counter sequencer for the RV32I fetch path. It owns the PC register and drives the select line of the branch-target mux (0 = sequential PC+4, 1 = resolved branch target). It holds redirects that arrive during pipeline stalls and issues a timed flush to the IF/ID stages after each redirect. It traps on misaligned branch targets.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
FLUSH_CYCLES, 2, number of unstalled cycles flush stays asserted after a redirect (legal range 1..15).

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
stall  input  1  pipeline stall; when high, PC and flush counter freeze.
branchTaken  input  1  EX stage resolved a taken branch/jump this cycle.
branchTarget  input  32  resolved target address; valid when branchTaken=1.
pc  output  32  current fetch address (registered).
pcSelect  output  1  branch-mux select; 1 exactly in the cycle pc loads a target (combinational).
nextPc  output  32  value pc loads at next edge (mux result, combinational).
flush  output  1  kill wrong-path instructions in IF/ID (registered).
misalignedTarget  output  1  sticky trap flag (registered).
redirectCount  output  16  number of completed redirects; saturates at 16'hFFFF.

Behaviour:
- Reset (reset=1 at an edge, has priority over all inputs): pc=RESET_PC, flush=0, misalignedTarget=0, redirectCount=0, pendingTarget=0, flushCnt=0, state=RUN. Reset asserted in any state, including mid-flush or PENDING, discards the pending redirect.
- States: RUN, PENDING, FLUSH, TRAP.
- Misaligned check: branchTarget[1:0]!=0 (RV32I without C extension).
- RUN:
  - branchTaken=1 with a misaligned target -> TRAP. pc holds and misalignedTarget=1 next cycle. This check applies regardless of stall.
  - branchTaken=1, aligned, stall=0 -> pcSelect=1, pc<=branchTarget, flushCnt<=FLUSH_CYCLES, flush<=1, redirectCount+1, go to FLUSH.
  - branchTaken=1, aligned, stall=1 -> pendingTarget<=branchTarget, pc holds, go to PENDING. pcSelect=0.
  - branchTaken=0: stall=1 holds pc. stall=0 sets pc<=pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- PENDING:
  - stall=1: hold everything.
  - stall=0: pcSelect=1, pc<=pendingTarget, flush<=1, flushCnt<=FLUSH_CYCLES, redirectCount+1, go to FLUSH.
  - branchTaken is ignored in PENDING because it comes from a younger, wrong-path instruction.
- FLUSH:
  - flush=1 throughout.
  - stall=1: pc and flushCnt frozen.
  - stall=0: pc<=pc+4 and flushCnt decrements. When flushCnt==1 and stall=0, flush<=0 and the state goes to RUN.
  - branchTaken is ignored in FLUSH.
- TRAP: pc frozen, flush=1, misalignedTarget=1. All inputs are ignored until reset.
- nextPc always equals the value pc takes at the next edge, absent reset.
- pcSelect=0 in every cycle other than the redirect load cycle.
- redirectCount increments only on a successful load. It holds at 16'hFFFF.
- Back-to-back redirect: a branch in the first RUN cycle after FLUSH is accepted normally.

Test Plan:
- Reset then 3 unstalled cycles -> pc = 0x0, 0x4, 0x8, 0xC; flush=0; pcSelect=0.
- At pc=0x10, branchTaken=1, target=0x100, stall=0 -> pcSelect=1 that cycle; pc=0x100 next; flush=1 for 2 cycles (pc 0x100, 0x104); RUN at pc=0x108; redirectCount=1.
- At pc=0x20, branchTaken=1, target=0x200, stall=1 for 3 cycles, with branchTaken=1 target=0x300 in the 2nd cycle -> pc stays 0x20; on stall release pc=0x200, never 0x300; flush then follows the FLUSH_CYCLES timing.
- During FLUSH, stall=1 for 2 cycles -> flush stays high and pc frozen; flush deasserts only after 2 unstalled cycles in total.
- branchTaken=1, target=0x102 -> misalignedTarget=1, flush=1, pc frozen for 10 cycles despite further branches; reset -> pc=RESET_PC and all flags clear.
- pc=0xFFFF_FFF8 unstalled -> 0xFFFF_FFFC, then 0x0000_0000. Force redirectCount to 0xFFFF, then redirect -> redirectCount stays 0xFFFF.

Source files
------------

// File: rtl/branch_pc_ctrl_if.sv
// ============================================================================
// Module      : branch_pc_ctrl_if
// Description : Fetch-redirect bus between the EX/stall logic and the PC
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface branch_pc_ctrl_if;
    logic        stall;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic [31:0] pc;
    logic        pcSelect;
    logic [31:0] nextPc;
    logic        flush;
    logic        misalignedTarget;
    logic [15:0] redirectCount;

    modport master (
        output stall, branchTaken, branchTarget,
        input  pc, pcSelect, nextPc, flush, misalignedTarget, redirectCount
    );

    modport slave (
        input  stall, branchTaken, branchTarget,
        output pc, pcSelect, nextPc, flush, misalignedTarget, redirectCount
    );
endinterface

`default_nettype wire

// File: rtl/branch_pc_ctrl.sv
// ============================================================================
// Module      : branch_pc_ctrl
// Description : RV32I program-counter sequencer with stall-held redirects,
//               timed IF/ID flush and misaligned-target trap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_pc_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    branch_pc_ctrl_if.slave   bus
);

    localparam logic [3:0]  C_FLUSH_INIT = FLUSH_CYCLES[3:0];
    localparam logic [15:0] C_CNT_MAX    = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PENDING = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_TRAP    = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pending_target;
    logic [3:0]  r_flush_cnt;
    logic        r_flush;
    logic        r_misaligned;
    logic [15:0] r_redirect_cnt;

    logic        w_misaligned;
    logic        w_pc_select;
    logic [31:0] w_next_pc;
    logic [31:0] w_pc_plus4;

    assign w_misaligned = (bus.branchTarget[1:0] != 2'b00);
    assign w_pc_plus4   = r_pc + 32'd4;

    // Branch-mux select and next fetch address; mirrors the state update below.
    always_comb begin
        w_pc_select = 1'b0;
        w_next_pc   = r_pc;
        case (r_state)
            ST_RUN: begin
                if (bus.branchTaken) begin
                    if (!w_misaligned && !bus.stall) begin
                        w_pc_select = 1'b1;
                        w_next_pc   = bus.branchTarget;
                    end
                end else if (!bus.stall) begin
                    w_next_pc = w_pc_plus4;
                end
            end
            ST_PENDING: begin
                if (!bus.stall) begin
                    w_pc_select = 1'b1;
                    w_next_pc   = r_pending_target;
                end
            end
            ST_FLUSH: begin
                if (!bus.stall) begin
                    w_next_pc = w_pc_plus4;
                end
            end
            default: begin
                w_next_pc = r_pc;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= ST_RUN;
            r_pc             <= RESET_PC;
            r_pending_target <= 32'd0;
            r_flush_cnt      <= 4'd0;
            r_flush          <= 1'b0;
            r_misaligned     <= 1'b0;
            r_redirect_cnt   <= 16'd0;
        end else begin
            r_pc <= w_next_pc;
            case (r_state)
                ST_RUN: begin
                    if (bus.branchTaken) begin
                        if (w_misaligned) begin
                            r_state      <= ST_TRAP;
                            r_misaligned <= 1'b1;
                            r_flush      <= 1'b1;
                        end else if (!bus.stall) begin
                            r_state     <= ST_FLUSH;
                            r_flush     <= 1'b1;
                            r_flush_cnt <= C_FLUSH_INIT;
                            if (r_redirect_cnt != C_CNT_MAX) begin
                                r_redirect_cnt <= r_redirect_cnt + 16'd1;
                            end
                        end else begin
                            r_state          <= ST_PENDING;
                            r_pending_target <= bus.branchTarget;
                        end
                    end
                end
                // Younger branches seen here are wrong-path and are dropped.
                ST_PENDING: begin
                    if (!bus.stall) begin
                        r_state     <= ST_FLUSH;
                        r_flush     <= 1'b1;
                        r_flush_cnt <= C_FLUSH_INIT;
                        if (r_redirect_cnt != C_CNT_MAX) begin
                            r_redirect_cnt <= r_redirect_cnt + 16'd1;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (!bus.stall) begin
                        r_flush_cnt <= r_flush_cnt - 4'd1;
                        if (r_flush_cnt == 4'd1) begin
                            r_flush <= 1'b0;
                            r_state <= ST_RUN;
                        end
                    end
                end
                default: begin
                    r_state <= ST_TRAP;
                end
            endcase
        end
    end

    assign bus.pc               = r_pc;
    assign bus.pcSelect         = w_pc_select;
    assign bus.nextPc           = w_next_pc;
    assign bus.flush            = r_flush;
    assign bus.misalignedTarget = r_misaligned;
    assign bus.redirectCount    = r_redirect_cnt;

endmodule

`default_nettype wire

// File: tb/tb_branch_pc_ctrl.sv
// ============================================================================
// Module      : tb_branch_pc_ctrl
// Description : Directed self-checking bench for branch_pc_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_pc_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    branch_pc_ctrl_if bus ();

    branch_pc_ctrl #(
        .RESET_PC     (32'h0000_0000),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic bt, input logic [31:0] tgt);
        bus.stall        = s;
        bus.branchTaken  = bt;
        bus.branchTarget = tgt;
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        drive(1'b0, 1'b0, 32'h0);
        tick();
        tick();
        reset = 1'b0;

        // Reset state and sequential fetch
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_flush", bus.flush, 1'b0);
        chk("rst_mis", bus.misalignedTarget, 1'b0);
        chk("rst_cnt", bus.redirectCount, 16'd0);
        chk("rst_sel", bus.pcSelect, 1'b0);
        chk("rst_next", bus.nextPc, 32'h4);
        tick();
        chk("seq_pc4", bus.pc, 32'h4);
        tick();
        chk("seq_pc8", bus.pc, 32'h8);
        tick();
        chk("seq_pcC", bus.pc, 32'hC);
        chk("seq_flush", bus.flush, 1'b0);
        tick();
        chk("seq_pc10", bus.pc, 32'h10);

        // Unstalled redirect to 0x100
        drive(1'b0, 1'b1, 32'h100);
        chk("br_sel", bus.pcSelect, 1'b1);
        chk("br_next", bus.nextPc, 32'h100);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        chk("br_pc", bus.pc, 32'h100);
        chk("br_flush1", bus.flush, 1'b1);
        chk("br_sel_after", bus.pcSelect, 1'b0);
        chk("br_cnt", bus.redirectCount, 16'd1);
        tick();
        chk("br_pc104", bus.pc, 32'h104);
        chk("br_flush2", bus.flush, 1'b1);
        tick();
        chk("br_pc108", bus.pc, 32'h108);
        chk("br_flush_off", bus.flush, 1'b0);

        // Redirect during stall; younger branch in PENDING ignored
        drive(1'b1, 1'b1, 32'h200);
        chk("pend_sel0", bus.pcSelect, 1'b0);
        chk("pend_next0", bus.nextPc, 32'h108);
        tick();
        drive(1'b1, 1'b1, 32'h300);
        chk("pend_pc", bus.pc, 32'h108);
        chk("pend_sel1", bus.pcSelect, 1'b0);
        tick();
        drive(1'b1, 1'b0, 32'h0);
        chk("pend_hold", bus.pc, 32'h108);
        chk("pend_noflush", bus.flush, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        chk("pend_rel_sel", bus.pcSelect, 1'b1);
        chk("pend_rel_next", bus.nextPc, 32'h200);
        tick();
        chk("pend_pc200", bus.pc, 32'h200);
        chk("pend_flush", bus.flush, 1'b1);
        chk("pend_cnt", bus.redirectCount, 16'd2);

        // Stall inside FLUSH freezes pc and the flush timer
        drive(1'b1, 1'b1, 32'h600);
        chk("fst_next", bus.nextPc, 32'h200);
        tick();
        chk("fst_pc1", bus.pc, 32'h200);
        chk("fst_flush1", bus.flush, 1'b1);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        chk("fst_pc2", bus.pc, 32'h200);
        chk("fst_flush2", bus.flush, 1'b1);
        tick();
        chk("fst_pc204", bus.pc, 32'h204);
        chk("fst_flush3", bus.flush, 1'b1);
        tick();
        chk("fst_pc208", bus.pc, 32'h208);
        chk("fst_flush_off", bus.flush, 1'b0);

        // Back-to-back redirect, then wrap at top of address space
        drive(1'b0, 1'b1, 32'hFFFF_FFF0);
        chk("b2b_sel", bus.pcSelect, 1'b1);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        chk("b2b_pc", bus.pc, 32'hFFFF_FFF0);
        chk("b2b_cnt", bus.redirectCount, 16'd3);
        tick();
        tick();
        chk("wrap_pcF8", bus.pc, 32'hFFFF_FFF8);
        chk("wrap_flush", bus.flush, 1'b0);
        chk("wrap_nextFC", bus.nextPc, 32'hFFFF_FFFC);
        tick();
        chk("wrap_pcFC", bus.pc, 32'hFFFF_FFFC);
        chk("wrap_next0", bus.nextPc, 32'h0);
        tick();
        chk("wrap_pc0", bus.pc, 32'h0);

        // Saturation of redirectCount
        force dut.r_redirect_cnt = 16'hFFFF;
        #1;
        release dut.r_redirect_cnt;
        drive(1'b0, 1'b1, 32'h40);
        chk("sat_pre", bus.redirectCount, 16'hFFFF);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        chk("sat_cnt", bus.redirectCount, 16'hFFFF);
        chk("sat_pc", bus.pc, 32'h40);
        tick();
        tick();
        chk("sat_pc48", bus.pc, 32'h48);

        // Misaligned target traps even while stalled
        drive(1'b1, 1'b1, 32'h102);
        chk("trap_sel", bus.pcSelect, 1'b0);
        chk("trap_next", bus.nextPc, 32'h48);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(i[0], 1'b1, 32'h400 + 32'(i * 4));
            chk("trap_pc", bus.pc, 32'h48);
            chk("trap_mis", bus.misalignedTarget, 1'b1);
            chk("trap_flush", bus.flush, 1'b1);
            chk("trap_sel_i", bus.pcSelect, 1'b0);
            tick();
        end

        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        chk("trst_pc", bus.pc, 32'h0);
        chk("trst_mis", bus.misalignedTarget, 1'b0);
        chk("trst_flush", bus.flush, 1'b0);
        chk("trst_cnt", bus.redirectCount, 16'd0);

        // Reset while PENDING discards the held target
        drive(1'b1, 1'b1, 32'h500);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        chk("prst_sel", bus.pcSelect, 1'b0);
        chk("prst_next", bus.nextPc, 32'h4);
        tick();
        chk("prst_pc", bus.pc, 32'h4);
        chk("prst_flush", bus.flush, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
